// File: rtl/multicycle_stack_controller.sv
// Multi-cycle controller for the stack processor: sequences FETCH/DECODE/EXEC/MEM/WB,
// tracks stack occupancy, traps illegal/overflow/underflow/memory-timeout conditions.
module multicycle_stack_controller #(
  parameter int OPW         = 4,
  parameter int FW          = 2,
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16,
  localparam int SPW        = $clog2(STACK_DEPTH + 1),
  localparam int TW         = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   ir_1,
  input  logic [FW-1:0]    ir_2,
  input  logic [FW-1:0]    ir_3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       aluOp,
  output logic             memReadWrite,
  output logic             memReq,
  output logic             branch,
  output logic             regLoad,
  output logic [1:0]       muxPP,
  output logic             muxpush,
  output logic             muxreturn,
  output logic             irLoad,
  output logic             pcLoad,
  output logic             fault,
  output logic [2:0]       state,
  output logic [SPW-1:0]   sp_level,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_CALL  = 4'b1101;
  localparam logic [3:0] OP_RET   = 4'b1110;
  localparam logic [3:0] OP_STK   = 4'b1111;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             sub_q, sub_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic upper_bad;
  logic dec_push;
  logic dec_pop;
  logic unused_fields;

  generate
    if (OPW > 4) begin : g_upper
      assign upper_bad = |ir_1[OPW-1:4];
    end else begin : g_no_upper
      assign upper_bad = 1'b0;
    end
  endgenerate

  // Register fields are routed to the datapath directly; only the stack subtype bit matters here.
  assign unused_fields = ^{ir_2, ir_3};

  assign dec_push = (ir_1[3:0] == OP_CALL) || ((ir_1[3:0] == OP_STK) && !ir_2[0]);
  assign dec_pop  = (ir_1[3:0] == OP_RET)  || ((ir_1[3:0] == OP_STK) &&  ir_2[0]);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sub_d   = sub_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d  = ir_1[3:0];
        sub_d = ir_2[0];
        if (upper_bad || (ir_1[3:1] == 3'b101) ||
            (dec_push && (sp_q == SPW'(STACK_DEPTH))) ||
            (dec_pop && (sp_q == '0)))
          state_d = S_FAULT;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!op_q[3]) begin
          state_d = S_WB;
        end else begin
          case (op_q)
            OP_LOAD, OP_STORE: state_d = S_MEM;
            OP_BEQ: begin
              state_d = S_FETCH;
              cnt_d   = cnt_q + CNT_W'(1);
            end
            OP_CALL: begin
              sp_d    = sp_q + SPW'(1);
              state_d = S_FETCH;
              cnt_d   = cnt_q + CNT_W'(1);
            end
            OP_RET: begin
              sp_d    = sp_q - SPW'(1);
              state_d = S_FETCH;
              cnt_d   = cnt_q + CNT_W'(1);
            end
            OP_STK: begin
              if (sub_q) begin
                sp_d    = sp_q - SPW'(1);
                state_d = S_WB;
              end else begin
                sp_d    = sp_q + SPW'(1);
                state_d = S_FETCH;
                cnt_d   = cnt_q + CNT_W'(1);
              end
            end
            default: state_d = S_FAULT;
          endcase
        end
      end
      // A ready on the final allowed wait cycle still completes the access.
      S_MEM: begin
        if (mem_ready) begin
          tmo_d = '0;
          if (op_q == OP_STORE) begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      sub_q   <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Strobes are gated by reset so an aborted MEM access drops memReq at once.
  always_comb begin
    aluOp        = 2'b00;
    memReadWrite = 1'b0;
    memReq       = 1'b0;
    branch       = 1'b0;
    regLoad      = 1'b0;
    muxPP        = 2'b00;
    muxpush      = 1'b0;
    muxreturn    = 1'b0;
    irLoad       = 1'b0;
    pcLoad       = 1'b0;
    fault        = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          irLoad = 1'b1;
          pcLoad = 1'b1;
        end
        S_EXEC: begin
          if (!op_q[3]) begin
            aluOp = op_q[1:0];
          end else begin
            case (op_q)
              OP_BEQ: begin
                aluOp  = 2'b01;
                branch = 1'b1;
                pcLoad = zero;
              end
              OP_CALL: begin
                muxPP   = 2'b01;
                muxpush = 1'b1;
                branch  = 1'b1;
                pcLoad  = 1'b1;
              end
              OP_RET: begin
                muxPP     = 2'b10;
                muxreturn = 1'b1;
                pcLoad    = 1'b1;
              end
              OP_STK: muxPP = sub_q ? 2'b10 : 2'b01;
              default: aluOp = 2'b00;
            endcase
          end
        end
        S_MEM: begin
          memReq       = 1'b1;
          memReadWrite = (op_q == OP_STORE);
        end
        S_WB: begin
          regLoad = 1'b1;
          if (!op_q[3]) aluOp = op_q[1:0];
          if (op_q == OP_STK) muxPP = 2'b10;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

  assign state       = state_q;
  assign sp_level    = sp_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_stack_controller.sv
// Directed self-checking bench for multicycle_stack_controller (STACK_DEPTH=2, CNT_W=4, OPW=5).
module tb_multicycle_stack_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ir_1;
  logic [1:0] ir_2;
  logic [1:0] ir_3;
  logic       zero;
  logic       mem_ready;
  logic [1:0] aluOp;
  logic       memReadWrite;
  logic       memReq;
  logic       branch;
  logic       regLoad;
  logic [1:0] muxPP;
  logic       muxpush;
  logic       muxreturn;
  logic       irLoad;
  logic       pcLoad;
  logic       fault;
  logic [2:0] state;
  logic [1:0] sp_level;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  multicycle_stack_controller #(
    .OPW(5), .FW(2), .STACK_DEPTH(2), .MEM_TIMEOUT(16), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .ir_1(ir_1), .ir_2(ir_2), .ir_3(ir_3),
    .zero(zero), .mem_ready(mem_ready), .aluOp(aluOp),
    .memReadWrite(memReadWrite), .memReq(memReq), .branch(branch),
    .regLoad(regLoad), .muxPP(muxPP), .muxpush(muxpush),
    .muxreturn(muxreturn), .irLoad(irLoad), .pcLoad(pcLoad),
    .fault(fault), .state(state), .sp_level(sp_level),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic load_ir(input logic [3:0] op, input logic sub);
    ir_1 = {1'b0, op};
    ir_2 = {1'b0, sub};
    ir_3 = 2'b11;
  endtask

  // From FETCH, run through DECODE and stop in EXEC (or FAULT).
  task automatic to_exec(input logic [3:0] op, input logic sub);
    load_ir(op, sub);
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    load_ir(4'b0000, 1'b0);
    step();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (sp_level !== 2'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", sp_level); end
    checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    checks++; if ({irLoad, pcLoad, fault} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {irLoad, pcLoad, fault}); end
    reset = 1'b1;
    #1;
    checks++; if ({irLoad, pcLoad} !== 2'b11) begin errors++; $display("FAIL fetch_strobes: got %b want 11", {irLoad, pcLoad}); end
  endtask

  task automatic test_alu();
    load_ir(4'b0010, 1'b0);
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL alu_decode_state: got %0d want 1", state); end
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL alu_exec_state: got %0d want 2", state); end
    checks++; if (aluOp !== 2'b10 || regLoad !== 1'b0) begin errors++; $display("FAIL alu_exec_out: got aluOp=%b regLoad=%b want 10/0", aluOp, regLoad); end
    step();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL alu_wb_state: got %0d want 4", state); end
    checks++; if (aluOp !== 2'b10 || regLoad !== 1'b1) begin errors++; $display("FAIL alu_wb_out: got aluOp=%b regLoad=%b want 10/1", aluOp, regLoad); end
    step();
    checks++; if (state !== 3'd0 || instr_count !== 4'd1) begin errors++; $display("FAIL alu_retire: got state=%0d count=%0d want 0/1", state, instr_count); end
  endtask

  task automatic test_load();
    mem_ready = 1'b0;
    to_exec(4'b1000, 1'b0);
    checks++; if (state !== 3'd2 || aluOp !== 2'b00) begin errors++; $display("FAIL load_exec: got state=%0d aluOp=%b want 2/00", state, aluOp); end
    step();
    checks++; if (state !== 3'd3 || memReq !== 1'b1 || memReadWrite !== 1'b0) begin errors++; $display("FAIL load_mem1: got state=%0d req=%b rw=%b want 3/1/0", state, memReq, memReadWrite); end
    for (int i = 2; i <= 4; i++) begin
      step();
      checks++; if (state !== 3'd3 || memReq !== 1'b1) begin errors++; $display("FAIL load_mem_hold%0d: got state=%0d req=%b want 3/1", i, state, memReq); end
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++; if (state !== 3'd4 || regLoad !== 1'b1 || memReq !== 1'b0) begin errors++; $display("FAIL load_wb: got state=%0d regLoad=%b req=%b want 4/1/0", state, regLoad, memReq); end
    step();
    checks++; if (state !== 3'd0 || instr_count !== 4'd2) begin errors++; $display("FAIL load_retire: got state=%0d count=%0d want 0/2", state, instr_count); end
  endtask

  task automatic test_beq();
    zero = 1'b1;
    to_exec(4'b1100, 1'b0);
    checks++; if ({aluOp, branch, pcLoad} !== 4'b0111) begin errors++; $display("FAIL beq_taken: got aluOp/branch/pcLoad=%b want 0111", {aluOp, branch, pcLoad}); end
    step();
    zero = 1'b0;
    to_exec(4'b1100, 1'b0);
    checks++; if ({aluOp, branch, pcLoad} !== 4'b0110) begin errors++; $display("FAIL beq_not_taken: got aluOp/branch/pcLoad=%b want 0110", {aluOp, branch, pcLoad}); end
    step();
    checks++; if (state !== 3'd0 || instr_count !== 4'd4) begin errors++; $display("FAIL beq_retire: got state=%0d count=%0d want 0/4", state, instr_count); end
  endtask

  task automatic test_stack();
    to_exec(4'b1101, 1'b0);
    checks++; if ({muxPP, muxpush, branch, pcLoad, muxreturn} !== 6'b011110) begin errors++; $display("FAIL call_exec: got %b want 011110", {muxPP, muxpush, branch, pcLoad, muxreturn}); end
    checks++; if (sp_level !== 2'd0) begin errors++; $display("FAIL call_sp_before_exit: got %0d want 0", sp_level); end
    step();
    checks++; if (sp_level !== 2'd1 || instr_count !== 4'd5) begin errors++; $display("FAIL call_retire: got sp=%0d count=%0d want 1/5", sp_level, instr_count); end
    to_exec(4'b1111, 1'b0);
    checks++; if ({muxPP, muxpush, branch} !== 4'b0100) begin errors++; $display("FAIL push_exec: got %b want 0100", {muxPP, muxpush, branch}); end
    step();
    checks++; if (sp_level !== 2'd2 || instr_count !== 4'd6) begin errors++; $display("FAIL push_retire: got sp=%0d count=%0d want 2/6", sp_level, instr_count); end
    to_exec(4'b1111, 1'b1);
    checks++; if (muxPP !== 2'b10 || regLoad !== 1'b0) begin errors++; $display("FAIL pop_exec: got muxPP=%b regLoad=%b want 10/0", muxPP, regLoad); end
    step();
    checks++; if (state !== 3'd4 || regLoad !== 1'b1 || muxPP !== 2'b10 || sp_level !== 2'd1) begin errors++; $display("FAIL pop_wb: got state=%0d regLoad=%b muxPP=%b sp=%0d want 4/1/10/1", state, regLoad, muxPP, sp_level); end
    step();
    checks++; if (instr_count !== 4'd7) begin errors++; $display("FAIL pop_retire: got count=%0d want 7", instr_count); end
    to_exec(4'b1111, 1'b0);
    step();
    to_exec(4'b1111, 1'b0);
    checks++; if (state !== 3'd7 || fault !== 1'b1) begin errors++; $display("FAIL push_overflow: got state=%0d fault=%b want 7/1", state, fault); end
    step();
    checks++; if ({irLoad, pcLoad, muxPP, regLoad} !== 5'b00000 || sp_level !== 2'd2 || instr_count !== 4'd8) begin errors++; $display("FAIL overflow_hold: got strobes=%b sp=%0d count=%0d want 00000/2/8", {irLoad, pcLoad, muxPP, regLoad}, sp_level, instr_count); end
    do_reset();
    to_exec(4'b1110, 1'b0);
    checks++; if (state !== 3'd7 || fault !== 1'b1 || sp_level !== 2'd0) begin errors++; $display("FAIL ret_underflow: got state=%0d fault=%b sp=%0d want 7/1/0", state, fault, sp_level); end
  endtask

  task automatic test_illegal();
    do_reset();
    to_exec(4'b1010, 1'b0);
    checks++; if (state !== 3'd7 || fault !== 1'b1) begin errors++; $display("FAIL reserved_1010: got state=%0d fault=%b want 7/1", state, fault); end
    do_reset();
    ir_1 = 5'b10010;
    step();
    step();
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL upper_opcode_bits: got state=%0d want 7", state); end
  endtask

  task automatic test_store_timeout();
    int n;
    do_reset();
    to_exec(4'b0000, 1'b0);
    step();
    step();
    mem_ready = 1'b0;
    to_exec(4'b1001, 1'b0);
    step();
    checks++; if (state !== 3'd3 || memReq !== 1'b1 || memReadWrite !== 1'b1) begin errors++; $display("FAIL store_mem: got state=%0d req=%b rw=%b want 3/1/1", state, memReq, memReadWrite); end
    n = 0;
    while (state == 3'd3 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL store_timeout_cycles: got %0d want 16", n); end
    checks++; if (state !== 3'd7 || fault !== 1'b1 || memReq !== 1'b0 || instr_count !== 4'd1) begin errors++; $display("FAIL store_timeout_fault: got state=%0d fault=%b req=%b count=%0d want 7/1/0/1", state, fault, memReq, instr_count); end
    step();
    step();
    checks++; if (state !== 3'd7 || fault !== 1'b1 || {irLoad, pcLoad} !== 2'b00) begin errors++; $display("FAIL fault_sticky: got state=%0d fault=%b ir/pc=%b want 7/1/00", state, fault, {irLoad, pcLoad}); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    to_exec(4'b1101, 1'b0);
    step();
    mem_ready = 1'b0;
    to_exec(4'b1000, 1'b0);
    step();
    step();
    step();
    checks++; if (state !== 3'd3 || sp_level !== 2'd1 || instr_count !== 4'd1) begin errors++; $display("FAIL pre_abort: got state=%0d sp=%0d count=%0d want 3/1/1", state, sp_level, instr_count); end
    reset = 1'b0;
    #1;
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL abort_memreq: got %b want 0", memReq); end
    step();
    checks++; if (state !== 3'd0 || sp_level !== 2'd0 || instr_count !== 4'd0) begin errors++; $display("FAIL abort_reset: got state=%0d sp=%0d count=%0d want 0/0/0", state, sp_level, instr_count); end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    zero = 1'b0;
    for (int i = 0; i < 17; i++) begin
      to_exec(4'b1100, 1'b0);
      step();
    end
    checks++; if (state !== 3'd0 || instr_count !== 4'd1) begin errors++; $display("FAIL count_wrap: got state=%0d count=%0d want 0/1", state, instr_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_beq();
    test_stack();
    test_illegal();
    test_store_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
